vga_txt_addr: RTL

Text-mode character address generator for the VGA text controller. Sits directly downstream of the 10-pixel character tick counter. It consumes that counter's character tick (`i_t_h`) and the horizontal/vertical active-video enables, and tracks the current character column, character row and font scanline. From these it produces the linear text-RAM address and the font-ROM line index for the glyph fetch stage. Supports 64x25 and 64x30 layouts via parameters.

---
 rtl/vga_txt_addr.sv | 119 +++++++++++
 1 files changed

// File: rtl/vga_txt_addr.sv
// Text-mode character address generator: tracks column/row/scanline from the
// character tick and active-video enables, and emits text-RAM fetch addresses.
module vga_txt_addr #(
    parameter int unsigned COLS   = 64,
    parameter int unsigned ROWS   = 30,
    parameter int unsigned CHAR_H = 16,
    parameter int unsigned AW     = 11
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en_h,
    input  logic          i_en_v,
    input  logic          i_t_h,
    output logic [AW-1:0] o_addr,
    output logic [5:0]    o_col,
    output logic [4:0]    o_row,
    output logic [3:0]    o_line,
    output logic          o_fetch,
    output logic          o_frame_end
);

    localparam logic [5:0]    COL_LAST  = 6'(COLS - 1);
    localparam logic [4:0]    ROW_LAST  = 5'(ROWS - 1);
    localparam logic [3:0]    LINE_LAST = 4'(CHAR_H - 1);
    localparam logic [AW-1:0] ROW_STEP  = AW'(COLS);

    logic          en_h_d;
    logic          en_v_d;
    logic          h_armed;
    logic          in_line;
    logic          in_line_nxt;
    logic [5:0]    col;
    logic [5:0]    col_nxt;
    logic [4:0]    row;
    logic [4:0]    row_nxt;
    logic [3:0]    line;
    logic [3:0]    line_nxt;
    logic [AW-1:0] row_base;
    logic [AW-1:0] base_nxt;
    logic          fetch_nxt;
    logic          line_start;
    logic          line_end;
    logic          tick;

    // A line only counts once i_en_h has been seen low since reset; a reset in
    // mid-line therefore suppresses fetches until the next genuine rising edge.
    assign line_start = i_en_h & ~en_h_d & i_en_v & h_armed;
    assign line_end   = ~i_en_h & en_h_d & i_en_v & in_line;
    assign tick       = i_t_h & i_en_h & i_en_v & in_line;

    always_comb begin
        col_nxt     = col;
        row_nxt     = row;
        line_nxt    = line;
        base_nxt    = row_base;
        in_line_nxt = in_line;
        fetch_nxt   = 1'b0;
        if (!i_en_v) begin
            col_nxt     = '0;
            row_nxt     = '0;
            line_nxt    = '0;
            base_nxt    = '0;
            in_line_nxt = 1'b0;
        end else if (line_start) begin
            col_nxt     = '0;
            in_line_nxt = 1'b1;
            fetch_nxt   = 1'b1;
        end else if (tick) begin
            if (col < COL_LAST) begin
                col_nxt   = col + 6'd1;
                fetch_nxt = 1'b1;
            end
        end else if (line_end) begin
            in_line_nxt = 1'b0;
            if (line < LINE_LAST) begin
                line_nxt = line + 4'd1;
            end else begin
                line_nxt = '0;
                if (row < ROW_LAST) begin
                    row_nxt  = row + 5'd1;
                    base_nxt = row_base + ROW_STEP;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            en_h_d      <= 1'b0;
            en_v_d      <= 1'b0;
            h_armed     <= 1'b0;
            in_line     <= 1'b0;
            col         <= '0;
            row         <= '0;
            line        <= '0;
            row_base    <= '0;
            o_addr      <= '0;
            o_fetch     <= 1'b0;
            o_frame_end <= 1'b0;
        end else begin
            en_h_d      <= i_en_h;
            en_v_d      <= i_en_v;
            h_armed     <= h_armed | ~i_en_h;
            in_line     <= in_line_nxt;
            col         <= col_nxt;
            row         <= row_nxt;
            line        <= line_nxt;
            row_base    <= base_nxt;
            o_addr      <= base_nxt + AW'(col_nxt);
            o_fetch     <= fetch_nxt;
            o_frame_end <= ~i_en_v & en_v_d;
        end
    end

    assign o_col  = col;
    assign o_row  = row;
    assign o_line = line;

endmodule
